// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: takes a word over a valid/ready load
// handshake and streams it one bit per clock, framed by sout_valid/sout_last.
module piso_shift_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             c,
  input  logic             re,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             hold,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;

  always_comb begin
    sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    sout_valid = (state_q == SHIFT) & ~hold;
    sout_last  = sout_valid & (cnt_q == CNT_LAST);
    load_ready = (state_q == IDLE) | sout_last;
    accept     = load_valid & load_ready;
  end

  // A load on the final-bit cycle wins over the shift, giving a gapless stream.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      shreg_d = data_in;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (sout_valid) begin
      shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
      if (sout_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge c) begin
    if (re) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: MSB-first and LSB-first instances driven in lockstep,
// checked against a bit-queue scoreboard plus directed vectors.
module tb_piso_shift_tx;

  logic       c, re, load_valid, hold;
  logic [7:0] data_in;
  logic       rdy_m, sout_m, vld_m, last_m;
  logic       rdy_l, sout_l, vld_l, last_l;

  int checks = 0;
  int errors = 0;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .c(c), .re(re), .load_valid(load_valid), .load_ready(rdy_m), .data_in(data_in),
    .hold(hold), .sout(sout_m), .sout_valid(vld_m), .sout_last(last_m));

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .c(c), .re(re), .load_valid(load_valid), .load_ready(rdy_l), .data_in(data_in),
    .hold(hold), .sout(sout_l), .sout_valid(vld_l), .sout_last(last_l));

  initial c = 1'b0;
  always #5 c = ~c;

  typedef struct packed { logic b; logic last; } ent_t;
  ent_t qm[$];
  ent_t ql[$];

  // Scoreboard: each accepted word pushes its 8 expected bits; each valid cycle pops one.
  logic m_busy, m_vld, m_lst, m_rdy;
  always @(posedge c) begin
    m_busy = (qm.size() != 0);
    m_vld  = m_busy & ~hold;
    m_lst  = m_vld & qm[0].last;
    m_rdy  = ~m_busy | m_lst;
    if (re) begin
      qm.delete();
      ql.delete();
    end else begin
      if (m_vld) begin
        void'(qm.pop_front());
        void'(ql.pop_front());
      end
      if (load_valid && m_rdy) begin
        for (int i = 0; i < 8; i++) begin
          qm.push_back('{b: data_in[7-i], last: (i == 7)});
          ql.push_back('{b: data_in[i],   last: (i == 7)});
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic busy, e_vld, e_last, e_rdy, e_m, e_l;
    busy   = (qm.size() != 0);
    e_vld  = busy & ~hold;
    e_m    = busy ? qm[0].b : 1'b0;
    e_l    = busy ? ql[0].b : 1'b0;
    e_last = e_vld & (busy ? qm[0].last : 1'b0);
    e_rdy  = ~busy | e_last;
    chk("sb_sout_msb",  {15'd0, sout_m}, {15'd0, e_m});
    chk("sb_sout_lsb",  {15'd0, sout_l}, {15'd0, e_l});
    chk("sb_valid_msb", {15'd0, vld_m},  {15'd0, e_vld});
    chk("sb_valid_lsb", {15'd0, vld_l},  {15'd0, e_vld});
    chk("sb_last_msb",  {15'd0, last_m}, {15'd0, e_last});
    chk("sb_last_lsb",  {15'd0, last_l}, {15'd0, e_last});
    chk("sb_ready_msb", {15'd0, rdy_m},  {15'd0, e_rdy});
    chk("sb_ready_lsb", {15'd0, rdy_l},  {15'd0, e_rdy});
  endtask

  task automatic step(input logic r, input logic lv, input logic [7:0] d, input logic h);
    @(negedge c);
    re = r; load_valid = lv; data_in = d; hold = h;
    #1;
    compare_model();
  endtask

  typedef struct {
    logic       lv;
    logic [7:0] din;
    logic       hold;
    logic       e_msb, e_lsb, e_vld, e_last, e_rdy;
  } vec_t;

  vec_t       tbl[10];
  logic [7:0] w;
  logic [15:0] got16, gotl16, gotv16;
  logic [7:0]  gm8, gl8;
  int          n;

  initial begin
    re = 1'b1; load_valid = 1'b0; hold = 1'b0; data_in = 8'h00;
    @(posedge c); @(posedge c);

    // Reset state
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_sout",  {14'd0, sout_m, sout_l}, 16'd0);
    chk("rst_valid", {14'd0, vld_m, vld_l},   16'd0);
    chk("rst_last",  {14'd0, last_m, last_l}, 16'd0);
    chk("rst_ready", {14'd0, rdy_m, rdy_l},   16'd3);

    // Single word 8'hC1, both bit orders
    w = 8'hC1;
    tbl[0] = '{lv: 1'b1, din: w, hold: 1'b0, e_msb: 1'b0, e_lsb: 1'b0, e_vld: 1'b0, e_last: 1'b0, e_rdy: 1'b1};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{lv: 1'b0, din: 8'h00, hold: 1'b0, e_msb: w[8-i], e_lsb: w[i-1],
                 e_vld: 1'b1, e_last: (i == 8), e_rdy: (i == 8)};
    tbl[9] = '{lv: 1'b0, din: 8'h00, hold: 1'b0, e_msb: 1'b0, e_lsb: 1'b0, e_vld: 1'b0, e_last: 1'b0, e_rdy: 1'b1};
    for (int i = 0; i < 10; i++) begin
      step(1'b0, tbl[i].lv, tbl[i].din, tbl[i].hold);
      chk("vec_sout_msb", {15'd0, sout_m}, {15'd0, tbl[i].e_msb});
      chk("vec_sout_lsb", {15'd0, sout_l}, {15'd0, tbl[i].e_lsb});
      chk("vec_valid",    {15'd0, vld_m},  {15'd0, tbl[i].e_vld});
      chk("vec_last",     {15'd0, last_m}, {15'd0, tbl[i].e_last});
      chk("vec_ready",    {15'd0, rdy_m},  {15'd0, tbl[i].e_rdy});
    end

    // Back-to-back: 8'h0F offered through the final bit of 8'hC1
    step(1'b0, 1'b1, 8'hC1, 1'b0);
    got16 = '0; gotl16 = '0; gotv16 = '0;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, (i < 8), 8'h0F, 1'b0);
      got16[15-i] = sout_m; gotl16[15-i] = last_m; gotv16[15-i] = vld_m;
    end
    chk("b2b_stream", got16,  16'b1100_0001_0000_1111);
    chk("b2b_last",   gotl16, 16'h0101);
    chk("b2b_valid",  gotv16, 16'hFFFF);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("b2b_idle_valid", {15'd0, vld_m}, 16'd0);

    // Hold for 3 cycles after 2 bits
    step(1'b0, 1'b1, 8'hC1, 1'b0);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0, 8'h00, (i >= 3 && i <= 5));
      if (i >= 3 && i <= 5) chk("hold_sout_valid", {14'd0, sout_m, vld_m}, 16'd0);
      if (last_m) begin
        n = i;
        break;
      end
    end
    chk("hold_span", 16'(n), 16'd11);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Load attempts mid-word are ignored until the final bit
    step(1'b0, 1'b1, 8'hC1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 2; i <= 7; i++) begin
      step(1'b0, 1'b1, 8'hFF, 1'b0);
      chk("busy_ready", {15'd0, rdy_m}, 16'd0);
    end
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    chk("accept_on_last", {14'd0, last_m, rdy_m}, 16'd3);
    gm8 = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      gm8[7-i] = sout_m;
    end
    chk("ff_stream", {8'd0, gm8}, 16'h00FF);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Reset mid-word, then a fresh load with hold asserted in IDLE
    step(1'b0, 1'b1, 8'hC1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("midrst_outs",  {12'd0, sout_m, vld_m, last_m, rdy_m}, 16'd1);
    chk("midrst_lsb",   {12'd0, sout_l, vld_l, last_l, rdy_l}, 16'd1);
    step(1'b0, 1'b1, 8'h80, 1'b1);
    gm8 = '0; gl8 = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      gm8[7-i] = sout_m; gl8[7-i] = sout_l;
    end
    chk("fresh_msb", {8'd0, gm8}, 16'h0080);
    chk("fresh_lsb", {8'd0, gl8}, 16'h0001);

    // Random traffic against the scoreboard
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 59) == 0), $urandom_range(0, 1), 8'($urandom),
           ($urandom_range(0, 3) == 0));
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("drain_idle", {14'd0, vld_m, rdy_m}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
